a_x_feeder: RTL and testbench

- Buffered source stage that sits directly upstream of module a.
- Accepts 4-bit nibbles over a valid/ready handshake, stores them in a small register FIFO, and presents the head entry on x with x_valid/x_ready flow control.
- Exposes occupancy, full/empty, a peak-occupancy watermark, and a synchronous flush for testbench and auto-instance flows.

---
 rtl/a_x_feeder.sv | 99 +++++++++
 tb/tb_a_x_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/a_x_feeder.sv
// Register FIFO feeding module a: nibbles in over valid/ready, head entry out on x.
// Tracks occupancy, full/empty and a peak-occupancy watermark; clr flushes everything synchronously.
module a_x_feeder #(
    parameter  int DW    = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] x,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   peak
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   peak_q, peak_d;
    logic          push, pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full && !clr;
    assign x_valid  = !empty;
    assign x        = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign peak     = peak_q;

    // A handshake seen while clr is high is not a transfer.
    assign push = in_valid && in_ready;
    assign pop  = x_valid && x_ready && !clr;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        peak_d   = peak_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        if (count_d > peak_q) begin
            peak_d = count_d;
        end

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            peak_d   = '0;
        end
    end

    // Storage is deliberately left unreset; empty masks stale contents on x.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            peak_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            peak_q   <= peak_d;
        end
    end

endmodule

// File: tb/tb_a_x_feeder.sv
// Directed testbench for a_x_feeder: reset, fill, wrap-around drain, simultaneous push/pop,
// the DEPTH-1 boundary, synchronous flush and asynchronous reset mid-operation.
module tb_a_x_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] x;
    logic       x_valid;
    logic       x_ready = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [2:0] peak;

    int vectors = 0;
    int miscompares = 0;

    a_x_feeder #(.DW(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .peak     (peak)
    );

    always #5 clk = ~clk;

    // Drives one word for a single edge; outputs are sampled 1ns after that edge.
    task automatic push_word(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_x_valid: got %0b expected 0", x_valid); end
        vectors++; if (x !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_x: got %h expected 0", x); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %0b expected 0", full); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        vectors++; if (peak !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_peak: got %0d expected 0", peak); end
    endtask

    task automatic test_fill();
        logic [3:0] d;
        x_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            d = 4'(i);
            push_word(d);
            vectors++; if (count !== 3'(i)) begin miscompares++; $display("[TB] FAIL fill_count_%0d: got %0d expected %0d", i, count, i); end
            vectors++; if (x !== 4'h1 || x_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_head_%0d: got x=%h v=%0b expected x=1 v=1", i, x, x_valid); end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_full: got %0b expected 1", full); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_in_ready: got %0b expected 0", in_ready); end
        vectors++; if (peak !== 3'd4) begin miscompares++; $display("[TB] FAIL fill_peak: got %0d expected 4", peak); end
        push_word(4'h5);
        vectors++; if (count !== 3'd4 || x !== 4'h1) begin miscompares++; $display("[TB] FAIL fill_overflow: got count=%0d x=%h expected count=4 x=1", count, x); end
    endtask

    task automatic test_drain_wrap();
        logic [3:0] pend[$];
        logic [3:0] exp_x   [6];
        logic       exp_rdy [6];
        logic       took;
        pend    = '{4'h5, 4'h6};
        exp_x   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        exp_rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            x_ready  = 1'b1;
            in_valid = (pend.size() > 0);
            in_data  = in_valid ? pend[0] : 4'h0;
            #2;
            vectors++; if (x !== exp_x[k] || x_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_x_%0d: got x=%h v=%0b expected x=%h v=1", k, x, x_valid, exp_x[k]); end
            if (in_valid) begin
                vectors++; if (in_ready !== exp_rdy[k]) begin miscompares++; $display("[TB] FAIL drain_in_ready_%0d: got %0b expected %0b", k, in_ready, exp_rdy[k]); end
            end
            took = in_valid && exp_rdy[k];
            @(posedge clk);
            if (took) void'(pend.pop_front());
            #1;
        end
        x_ready  = 1'b0;
        in_valid = 1'b0;
        vectors++; if (count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_empty: got count=%0d empty=%0b expected 0/1", count, empty); end
        vectors++; if (peak !== 3'd4) begin miscompares++; $display("[TB] FAIL drain_peak: got %0d expected 4", peak); end
    endtask

    task automatic test_simultaneous();
        push_word(4'hB);
        push_word(4'hC);
        vectors++; if (count !== 3'd2) begin miscompares++; $display("[TB] FAIL simul_setup_count: got %0d expected 2", count); end
        in_valid = 1'b1;
        in_data  = 4'hA;
        x_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++; if (count !== 3'd2 || x !== 4'hC) begin miscompares++; $display("[TB] FAIL simul_count_x: got count=%0d x=%h expected 2/C", count, x); end
        @(posedge clk);
        #1;
        vectors++; if (count !== 3'd1 || x !== 4'hA) begin miscompares++; $display("[TB] FAIL simul_tail: got count=%0d x=%h expected 1/A", count, x); end
        @(posedge clk);
        #1;
        x_ready = 1'b0;
        vectors++; if (empty !== 1'b1 || x !== 4'h0 || x_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_drained: got empty=%0b x=%h v=%0b expected 1/0/0", empty, x, x_valid); end
        vectors++; if (peak !== 3'd4) begin miscompares++; $display("[TB] FAIL simul_peak: got %0d expected 4", peak); end
    endtask

    task automatic test_boundary();
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h3);
        in_valid = 1'b1;
        in_data  = 4'h4;
        x_ready  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_ready  = 1'b0;
        vectors++; if (count !== 3'd3 || full !== 1'b0) begin miscompares++; $display("[TB] FAIL boundary_count_full: got count=%0d full=%0b expected 3/0", count, full); end
        vectors++; if (x !== 4'h2) begin miscompares++; $display("[TB] FAIL boundary_x: got %h expected 2", x); end
    endtask

    task automatic test_clr();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        x_ready  = 1'b1;
        #2;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_in_ready: got %0b expected 0", in_ready); end
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        x_ready  = 1'b0;
        vectors++; if (count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_count_empty: got count=%0d empty=%0b expected 0/1", count, empty); end
        vectors++; if (peak !== 3'd0) begin miscompares++; $display("[TB] FAIL clr_peak: got %0d expected 0", peak); end
        vectors++; if (x_valid !== 1'b0 || x !== 4'h0) begin miscompares++; $display("[TB] FAIL clr_x: got x=%h v=%0b expected 0/0", x, x_valid); end
        @(posedge clk);
        #1;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL clr_not_stored: got empty=%0b expected 1", empty); end
        push_word(4'h8);
        vectors++; if (x !== 4'h8 || peak !== 3'd1) begin miscompares++; $display("[TB] FAIL clr_restart: got x=%h peak=%0d expected 8/1", x, peak); end
    endtask

    task automatic test_async_reset();
        push_word(4'h9);
        vectors++; if (count !== 3'd2) begin miscompares++; $display("[TB] FAIL areset_setup: got %0d expected 2", count); end
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_count: got count=%0d empty=%0b expected 0/1", count, empty); end
        vectors++; if (x_valid !== 1'b0 || x !== 4'h0) begin miscompares++; $display("[TB] FAIL areset_x: got x=%h v=%0b expected 0/0", x, x_valid); end
        vectors++; if (peak !== 3'd0) begin miscompares++; $display("[TB] FAIL areset_peak: got %0d expected 0", peak); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (x_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("[TB] FAIL areset_release: got v=%0b count=%0d expected 0/0", x_valid, count); end
        push_word(4'h7);
        vectors++; if (x !== 4'h7 || x_valid !== 1'b1 || count !== 3'd1) begin miscompares++; $display("[TB] FAIL areset_first_push: got x=%h v=%0b count=%0d expected 7/1/1", x, x_valid, count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_boundary();
        test_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
